// File: rtl/bit_shift_seq.sv
// Sequential shift/rotate unit: one registered 1-bit shift step per clock,
// with valid/ready handshakes on both the request and the result side.
module bit_shift_seq #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SHIFT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0] in_amount,
  input  logic                   in_dir,
  input  logic                   in_wrap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SHIFT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_q, dir_d;
  logic                   wrap_q, wrap_d;

  logic [DATA_WIDTH-1:0]  step_right;
  logic [DATA_WIDTH-1:0]  step_left;
  logic                   fill_msb;
  logic                   fill_lsb;

  // The vacated bit is zero for a logical shift, or the bit falling off the
  // opposite end for a rotate.
  always_comb begin
    fill_msb   = wrap_q & data_q[0];
    fill_lsb   = wrap_q & data_q[DATA_WIDTH-1];
    step_right = {fill_msb, data_q[DATA_WIDTH-1:1]};
    step_left  = {data_q[DATA_WIDTH-2:0], fill_lsb};
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d = in_data;
          cnt_d  = in_amount;
          dir_d  = in_dir;
          wrap_d = in_wrap;
          if (in_amount == '0) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end

      StShift: begin
        data_d = dir_q ? step_right : step_left;
        cnt_d  = cnt_q - SHIFT_WIDTH'(1);
        if (cnt_q == SHIFT_WIDTH'(1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  // The data register only changes in IDLE/SHIFT, so out_data is stable while
  // a result is held under back-pressure.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StShift) || (state_q == StDone);
  assign out_data  = data_q;

endmodule

// File: tb/tb_bit_shift_seq.sv
// Bench for bit_shift_seq: directed vector table, handshake corner sequences,
// and randomized requests checked against an arithmetic shift/rotate model.
module tb_bit_shift_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_amount;
  logic          in_dir;
  logic          in_wrap;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  int vectors;
  int miscompares;

  bit_shift_seq #(
    .DATA_WIDTH (W),
    .SHIFT_WIDTH(SW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amount(in_amount),
    .in_dir   (in_dir),
    .in_wrap  (in_wrap),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    logic       wrap;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word shift/rotate by the full amount in one step.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a,
                                           input logic dir, input logic wrap);
    logic [15:0] t;
    int          r;
    if (wrap) begin
      r = a % W;
      if (dir) t = ({8'h00, d} >> r) | ({8'h00, d} << (W - r));
      else     t = ({8'h00, d} << r) | ({8'h00, d} >> (W - r));
      return t[7:0];
    end
    if (a >= W) return 8'h00;
    t = dir ? ({8'h00, d} >> a) : ({8'h00, d} << a);
    return t[7:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n && in_ready && out_valid) begin
      miscompares++;
      $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1, expected not both");
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One request: accept, scramble inputs while busy, stall the result, consume.
  task automatic run_req(input logic [7:0] d, input logic [2:0] a, input logic dr,
                         input logic wr, input int stall, output logic [7:0] res,
                         output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("in_ready_before_req", int'(in_ready), 1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = a;
    in_dir    = dr;
    in_wrap   = wr;
    @(posedge clk);
    #1;
    check("busy_after_accept", int'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_amount = 3'($urandom);
      in_dir    = 1'($urandom);
      in_wrap   = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check("out_valid_seen", int'(out_valid), 1);
    res = out_data;
    for (int i = 0; i < stall; i++) begin
      in_data = 8'($urandom);
      @(posedge clk);
      #1;
      check("stall_valid_held", int'(out_valid), 1);
      check("stall_data_stable", int'(out_data), int'(res));
      check("stall_in_ready_low", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("consumed_valid_low", int'(out_valid), 0);
    check("consumed_busy_low", int'(busy), 0);
    out_ready = 1'($urandom);
  endtask

  initial begin
    vec_t       tbl[8];
    logic [7:0] res;
    logic [7:0] d;
    logic [2:0] a;
    logic       dr;
    logic       wr;
    int         lat;
    int         guard;

    vectors     = 0;
    miscompares = 0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_amount   = '0;
    in_dir      = 1'b0;
    in_wrap     = 1'b0;
    out_ready   = 1'b0;
    rst_n       = 1'b0;

    tbl[0] = '{8'hB5, 3'd3, 1'b1, 1'b0, 8'h16};
    tbl[1] = '{8'hB5, 3'd2, 1'b0, 1'b0, 8'hD4};
    tbl[2] = '{8'hB5, 3'd3, 1'b1, 1'b1, 8'hB6};
    tbl[3] = '{8'hB5, 3'd2, 1'b0, 1'b1, 8'hD6};
    tbl[4] = '{8'h80, 3'd7, 1'b0, 1'b1, 8'h40};
    tbl[5] = '{8'hB5, 3'd0, 1'b1, 1'b0, 8'hB5};
    tbl[6] = '{8'h80, 3'd7, 1'b1, 1'b0, 8'h01};
    tbl[7] = '{8'hFF, 3'd7, 1'b0, 1'b0, 8'h80};

    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_busy", int'(busy), 0);
    do_reset();
    check("reset_in_ready", int'(in_ready), 1);

    foreach (tbl[i]) begin
      run_req(tbl[i].data, tbl[i].amt, tbl[i].dir, tbl[i].wrap, i % 3, res, lat);
      check($sformatf("vec%0d_data", i), int'(res), int'(tbl[i].exp));
      check($sformatf("vec%0d_latency", i), lat, int'(tbl[i].amt));
    end

    // Asynchronous reset while a result is held in DONE.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hB5;
    in_amount = 3'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_reset_valid", int'(out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_out_data", int'(out_data), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // Back-pressure with a queued request waiting on in_valid.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hB5;
    in_amount = 3'd3;
    in_dir    = 1'b1;
    in_wrap   = 1'b0;
    @(posedge clk);
    #1;
    guard = 0;
    while (!out_valid && guard < 40) begin
      in_data   = 8'($urandom);
      in_amount = 3'($urandom);
      @(posedge clk);
      #1;
      guard++;
    end
    check("bp_latency", guard, 3);
    in_data   = 8'h01;
    in_amount = 3'd1;
    in_dir    = 1'b0;
    in_wrap   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_data", int'(out_data), 8'h16);
      check("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("queued_accept_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    check("queued_valid", int'(out_valid), 1);
    check("queued_data", int'(out_data), 8'h02);
    @(posedge clk);
    #1;

    // Reset three shift edges into a 7-step request: transaction is dropped.
    in_valid  = 1'b1;
    in_data   = 8'hB5;
    in_amount = 3'd7;
    in_dir    = 1'b1;
    in_wrap   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midshift_rst_busy", int'(busy), 0);
    check("midshift_rst_data", int'(out_data), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("midshift_no_valid", int'(out_valid), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_req(8'h01, 3'd1, 1'b0, 1'b0, 0, res, lat);
    check("after_rst_data", int'(res), 8'h02);
    check("after_rst_latency", lat, 1);

    for (int n = 0; n < 60; n++) begin
      d  = 8'($urandom);
      a  = 3'($urandom);
      dr = 1'($urandom);
      wr = 1'($urandom);
      run_req(d, a, dr, wr, int'($urandom_range(0, 3)), res, lat);
      check($sformatf("rand%0d_data", n), int'(res), int'(ref_shift(d, int'(a), dr, wr)));
      check($sformatf("rand%0d_latency", n), lat, int'(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
